// File: rtl/wb_mailbox_pkg.sv
// Shared constants for the Wishbone mailbox: register offsets, bit positions
// inside STATUS and CTRL, and the response FSM state encoding.
package wb_mailbox_pkg;

  localparam logic [3:0] OFS_DATA   = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_CTRL   = 4'h8;

  localparam int ST_EMPTY_BIT    = 8;
  localparam int ST_FULL_BIT     = 9;
  localparam int ST_OVERFLOW_BIT = 10;

  localparam int CTRL_FLUSH_BIT   = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/mbox_fifo.sv
// Mailbox storage: circular buffer with read/write pointers and an occupancy
// count one bit wider than the pointers so that full and empty are distinct.
module mbox_fifo
  import wb_mailbox_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [31:0]              wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              head
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is deliberately left out of reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally modulo DEPTH; flush discards all entries at once.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/wb_mailbox_slave.sv
// Wishbone slave exposing a word FIFO: DATA pushes/pops, STATUS reports
// occupancy and a sticky overflow flag, CTRL flushes and clears overflow.
// Every selected request gets exactly one registered termination cycle.
module wb_mailbox_slave
  import wb_mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 8
) (
  input  logic        clk_i,
  input  logic        ext_rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [3:0]  sel_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic        not_empty_o
);

  localparam int AW = $clog2(DEPTH);

  state_t        state;
  logic          overflow;
  logic          sel;
  logic [3:0]    ofs;
  logic          push;
  logic          pop;
  logic          flush;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic [31:0]   fifo_head;
  logic [31:0]   status_word;

  assign sel = cyc_i && stb_i && (addr_i[31:4] == BASE_ADDR[31:4]);
  assign ofs = addr_i[3:0];

  assign status_word = {21'b0, overflow, fifo_full, fifo_empty, 8'(fifo_count)};

  // FIFO side effects are only taken when a request is accepted in IDLE.
  always_comb begin
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
    if (state == ST_IDLE && sel) begin
      case (ofs)
        OFS_DATA: begin
          if (we_i) push = (sel_i == 4'hF) && !fifo_full;
          else      pop  = !fifo_empty;
        end
        OFS_CTRL: flush = we_i && dat_i[CTRL_FLUSH_BIT];
        default:  ;
      endcase
    end
  end

  // Two-state response FSM with registered terminations and read data.
  always_ff @(posedge clk_i) begin
    if (!ext_rst_i) begin
      state    <= ST_IDLE;
      overflow <= 1'b0;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      rty_o    <= 1'b0;
      dat_o    <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      rty_o <= 1'b0;
      dat_o <= '0;
      case (state)
        ST_IDLE: begin
          if (sel) begin
            state <= ST_RESP;
            case (ofs)
              OFS_DATA: begin
                if (we_i) begin
                  if (sel_i != 4'hF) begin
                    err_o <= 1'b1;
                  end else if (fifo_full) begin
                    rty_o    <= 1'b1;
                    overflow <= 1'b1;
                  end else begin
                    ack_o <= 1'b1;
                  end
                end else if (fifo_empty) begin
                  rty_o <= 1'b1;
                end else begin
                  ack_o <= 1'b1;
                  dat_o <= fifo_head;
                end
              end
              OFS_STATUS: begin
                ack_o <= 1'b1;
                if (!we_i) dat_o <= status_word;
              end
              OFS_CTRL: begin
                ack_o <= 1'b1;
                if (we_i && dat_i[CTRL_CLR_OVF_BIT]) overflow <= 1'b0;
              end
              default: err_o <= 1'b1;
            endcase
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  mbox_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (ext_rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (dat_i),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign not_empty_o = !fifo_empty;

endmodule

// File: tb/tb_wb_mailbox_slave.sv
// Directed bench for wb_mailbox_slave with hand-computed expected values.
module tb_wb_mailbox_slave;

  logic        clk = 1'b0;
  logic        ext_rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic        ack, err, rty, not_empty;

  int n_assert = 0;
  int n_fail   = 0;

  logic        r_ack, r_err, r_rty;
  logic [31:0] r_dat;

  always #5 clk = ~clk;

  wb_mailbox_slave #(
    .BASE_ADDR (32'h0000_3000),
    .DEPTH     (8)
  ) dut (
    .clk_i       (clk),
    .ext_rst_i   (ext_rst),
    .addr_i      (addr),
    .dat_i       (wdat),
    .dat_o       (rdat),
    .we_i        (we),
    .cyc_i       (cyc),
    .stb_i       (stb),
    .sel_i       (sel),
    .ack_o       (ack),
    .err_o       (err),
    .rty_o       (rty),
    .not_empty_o (not_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One Wishbone access: drive on a falling edge, sample the RESP cycle on the next.
  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s);
    @(negedge clk);
    addr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    r_ack = ack; r_err = err; r_rty = rty; r_dat = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    // Reset
    ext_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rty", {31'b0, rty}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_ne",  {31'b0, not_empty}, 32'd0);
    ext_rst = 1'b1;

    // STATUS after reset
    access(32'h3004, 1'b0, 32'd0, 4'hF);
    chk("st0_ack", {31'b0, r_ack}, 32'd1);
    chk("st0_dat", r_dat, 32'h0000_0100);

    // Two pushes, two pops
    access(32'h3000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    chk("push1_ack", {31'b0, r_ack}, 32'd1);
    access(32'h3000, 1'b1, 32'h1234_5678, 4'hF);
    chk("push2_ack", {31'b0, r_ack}, 32'd1);
    chk("ne_after_push", {31'b0, not_empty}, 32'd1);
    access(32'h3000, 1'b0, 32'd0, 4'hF);
    chk("pop1_ack", {31'b0, r_ack}, 32'd1);
    chk("pop1_dat", r_dat, 32'hDEAD_BEEF);
    chk("ne_after_pop1", {31'b0, not_empty}, 32'd1);
    access(32'h3000, 1'b0, 32'd0, 4'hF);
    chk("pop2_ack", {31'b0, r_ack}, 32'd1);
    chk("pop2_dat", r_dat, 32'h1234_5678);
    chk("ne_after_pop2", {31'b0, not_empty}, 32'd0);

    // Fill, overflow, clear overflow, flush
    for (int i = 0; i < 8; i++) begin
      access(32'h3000, 1'b1, 32'hA000_0000 + i, 4'hF);
    end
    chk("fill_last_ack", {31'b0, r_ack}, 32'd1);
    access(32'h3000, 1'b1, 32'hBAD0_0009, 4'hF);
    chk("ovf_rty", {31'b0, r_rty}, 32'd1);
    chk("ovf_noack", {31'b0, r_ack}, 32'd0);
    access(32'h3004, 1'b0, 32'd0, 4'hF);
    chk("st_full_ovf", r_dat, 32'h0000_0608);
    access(32'h3008, 1'b1, 32'h2, 4'hF);
    chk("ctrl_clr_ack", {31'b0, r_ack}, 32'd1);
    access(32'h3004, 1'b0, 32'd0, 4'hF);
    chk("st_full", r_dat, 32'h0000_0208);
    access(32'h3000, 1'b0, 32'd0, 4'hF);
    chk("full_head", r_dat, 32'hA000_0000);
    access(32'h3008, 1'b1, 32'h1, 4'hF);
    access(32'h3004, 1'b0, 32'd0, 4'hF);
    chk("st_flushed", r_dat, 32'h0000_0100);

    // Error and retry cases
    access(32'h3000, 1'b0, 32'd0, 4'hF);
    chk("empty_rty", {31'b0, r_rty}, 32'd1);
    chk("empty_dat", r_dat, 32'd0);
    access(32'h300C, 1'b0, 32'd0, 4'hF);
    chk("bad_ofs_err", {31'b0, r_err}, 32'd1);
    access(32'h3000, 1'b1, 32'h5555_AAAA, 4'hF);
    access(32'h3000, 1'b1, 32'h7777_7777, 4'h3);
    chk("sel_err", {31'b0, r_err}, 32'd1);
    chk("sel_noack", {31'b0, r_ack}, 32'd0);
    access(32'h3004, 1'b0, 32'd0, 4'hF);
    chk("sel_count", r_dat, 32'h0000_0001);
    access(32'h3008, 1'b0, 32'd0, 4'hF);
    chk("ctrl_rd_ack", {31'b0, r_ack}, 32'd1);
    chk("ctrl_rd_dat", r_dat, 32'd0);
    access(32'h3004, 1'b1, 32'hFFFF_FFFF, 4'hF);
    chk("st_wr_ack", {31'b0, r_ack}, 32'd1);
    access(32'h3000, 1'b0, 32'd0, 4'hF);
    chk("sel_keep_dat", r_dat, 32'h5555_AAAA);

    // Unselected address: no termination within 4 cycles
    @(negedge clk);
    addr = 32'h4000; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("unsel_term", {29'b0, ack, err, rty}, 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;

    // Pointer wrap: 3 in/out, then 8 in/out
    for (int i = 0; i < 3; i++) access(32'h3000, 1'b1, 32'h1000_0000 + i, 4'hF);
    for (int i = 0; i < 3; i++) begin
      access(32'h3000, 1'b0, 32'd0, 4'hF);
      chk("wrap_a", r_dat, 32'h1000_0000 + i);
    end
    for (int i = 0; i < 8; i++) access(32'h3000, 1'b1, 32'h2000_0000 + i, 4'hF);
    for (int i = 0; i < 8; i++) begin
      access(32'h3000, 1'b0, 32'd0, 4'hF);
      chk("wrap_b", r_dat, 32'h2000_0000 + i);
    end

    // Reset asserted during RESP aborts the response
    access(32'h3000, 1'b1, 32'hCAFE_0001, 4'hF);
    @(negedge clk);
    addr = 32'h3004; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    chk("pre_rst_ack", {31'b0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0;
    ext_rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_term", {29'b0, ack, err, rty}, 32'd0);
    chk("rst_resp_ne", {31'b0, not_empty}, 32'd0);
    ext_rst = 1'b1;
    access(32'h3004, 1'b0, 32'd0, 4'hF);
    chk("st_after_rst", r_dat, 32'h0000_0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
